// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared types and constants for the FP adder dispatch front-end
package fpu_pkg;

  typedef enum logic [1:0] {
    D_IDLE  = 2'd0,
    D_ISSUE = 2'd1,
    D_WAIT  = 2'd2,
    D_FLUSH = 2'd3
  } dispatch_state_t;

  // Adder controller sequencing, kept here so both sides share one definition
  typedef enum logic [2:0] {
    A_IDLE   = 3'd0,
    A_UNPACK = 3'd1,
    A_ALIGN  = 3'd2,
    A_ADD    = 3'd3,
    A_NORM   = 3'd4,
    A_ROUND  = 3'd5,
    A_DONE   = 3'd6
  } add_ctrl_state_t;

  localparam logic [2:0] EXC_NONE      = 3'b000;
  localparam logic [2:0] EXC_UNDERFLOW = 3'b001;
  localparam logic [2:0] EXC_OVERFLOW  = 3'b010;

  localparam int OP_W   = 32;
  localparam int MODE_W = 3;

  function automatic int req_width(input int tag_w);
    return 2 * OP_W + MODE_W + tag_w;
  endfunction

endpackage

// File: rtl/fpu_add_dispatch_if.sv
// rtl/fpu_add_dispatch_if.sv - request, adder-controller and result ports of the dispatcher
interface fpu_add_dispatch_if #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             In_valid;
  logic             In_ready;
  logic [31:0]      In_op1;
  logic [31:0]      In_op2;
  logic [2:0]       In_mode;
  logic [TAG_W-1:0] In_tag;

  logic [31:0]      Add_datain1;
  logic [31:0]      Add_datain2;
  logic             Add_data_valid;
  logic [2:0]       Add_mode;
  logic [31:0]      Add_dataout;
  logic             Add_dataout_valid;
  logic [2:0]       Add_exc;

  logic             Out_valid;
  logic             Out_ready;
  logic [31:0]      Out_data;
  logic [2:0]       Out_exc;
  logic [TAG_W-1:0] Out_tag;
  logic             Out_timeout;

  logic             Busy;
  logic [CNT_W-1:0] Count;

  modport slave (
    input  In_valid, In_op1, In_op2, In_mode, In_tag,
    input  Add_dataout, Add_dataout_valid, Add_exc,
    input  Out_ready,
    output In_ready,
    output Add_datain1, Add_datain2, Add_data_valid, Add_mode,
    output Out_valid, Out_data, Out_exc, Out_tag, Out_timeout,
    output Busy, Count
  );

  modport master (
    output In_valid, In_op1, In_op2, In_mode, In_tag,
    output Add_dataout, Add_dataout_valid, Add_exc,
    output Out_ready,
    input  In_ready,
    input  Add_datain1, Add_datain2, Add_data_valid, Add_mode,
    input  Out_valid, Out_data, Out_exc, Out_tag, Out_timeout,
    input  Busy, Count
  );

endinterface

// File: rtl/fpu_sync_fifo.sv
// rtl/fpu_sync_fifo.sv - single-clock request FIFO; full/empty come from count, pointers wrap mod DEPTH
module fpu_sync_fifo
  import fpu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0] count_q;

  // Storage carries no reset; only the pointers and count define validity
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata = mem_q[rptr_q];
  assign count = count_q;

endmodule

// File: rtl/fpu_add_dispatch.sv
// rtl/fpu_add_dispatch.sv - queues FP add requests, issues one at a time and returns tagged results
module fpu_add_dispatch
  import fpu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 64
) (
  input logic               CLK,
  input logic               RST,
  fpu_add_dispatch_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam int FW    = req_width(TAG_W);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  dispatch_state_t  state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;

  logic [31:0]      op1_q, op1_d;
  logic [31:0]      op2_q, op2_d;
  logic [2:0]       mode_q, mode_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_data_q, out_data_d;
  logic [2:0]       out_exc_q, out_exc_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic             out_timeout_q, out_timeout_d;

  logic             push, pop;
  logic [CNT_W-1:0] count;
  logic [FW-1:0]    fifo_wdata, fifo_rdata;

  assign bus.In_ready = !RST && (count < CNT_W'(DEPTH));
  assign push         = bus.In_valid && bus.In_ready;
  // Issue only with an empty output slot so at most one result is ever pending
  assign pop          = (state_q == D_IDLE) && (count != '0) && !out_valid_q;
  assign fifo_wdata   = {bus.In_op1, bus.In_op2, bus.In_mode, bus.In_tag};

  fpu_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (push),
    .pop   (pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .count (count)
  );

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    op1_d         = op1_q;
    op2_d         = op2_q;
    mode_d        = mode_q;
    tag_d         = tag_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_exc_d     = out_exc_q;
    out_tag_d     = out_tag_q;
    out_timeout_d = out_timeout_q;

    if (out_valid_q && bus.Out_ready) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      D_IDLE: begin
        if (pop) begin
          {op1_d, op2_d, mode_d, tag_d} = fifo_rdata;
          state_d = D_ISSUE;
        end
      end
      D_ISSUE: begin
        timer_d = '0;
        state_d = D_WAIT;
      end
      D_WAIT: begin
        if (bus.Add_dataout_valid) begin
          out_valid_d   = 1'b1;
          out_data_d    = bus.Add_dataout;
          out_exc_d     = bus.Add_exc;
          out_tag_d     = tag_q;
          out_timeout_d = 1'b0;
          timer_d       = '0;
          state_d       = D_IDLE;
        end else if (timer_q == TMR_LAST) begin
          out_valid_d   = 1'b1;
          out_data_d    = '0;
          out_exc_d     = EXC_NONE;
          out_tag_d     = tag_q;
          out_timeout_d = 1'b1;
          timer_d       = '0;
          state_d       = D_FLUSH;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      D_FLUSH: begin
        // The abandoned request may still answer late; swallow that one pulse
        if (bus.Add_dataout_valid || (timer_q == TMR_LAST)) begin
          timer_d = '0;
          state_d = D_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = D_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= D_IDLE;
      timer_q       <= '0;
      op1_q         <= '0;
      op2_q         <= '0;
      mode_q        <= '0;
      tag_q         <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_exc_q     <= '0;
      out_tag_q     <= '0;
      out_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      op1_q         <= op1_d;
      op2_q         <= op2_d;
      mode_q        <= mode_d;
      tag_q         <= tag_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_exc_q     <= out_exc_d;
      out_tag_q     <= out_tag_d;
      out_timeout_q <= out_timeout_d;
    end
  end

  assign bus.Add_datain1    = op1_q;
  assign bus.Add_datain2    = op2_q;
  assign bus.Add_mode       = mode_q;
  assign bus.Add_data_valid = (state_q == D_ISSUE);

  assign bus.Out_valid   = out_valid_q;
  assign bus.Out_data    = out_data_q;
  assign bus.Out_exc     = out_exc_q;
  assign bus.Out_tag     = out_tag_q;
  assign bus.Out_timeout = out_timeout_q;

  assign bus.Busy  = (state_q != D_IDLE);
  assign bus.Count = count;

endmodule
